ramb4_s8_s16_fifo_ctl: RTL and testbench
========================================

Name: ramb4_s8_s16_fifo_ctl

Overview:
- Control stage that sits directly in front of the dual-port 8/16 block RAM (512 x 8 on port A, 256 x 16 on port B) and uses it as a width-converting FIFO.
- Byte producers push on the 8-bit side; this block drives port A writes.
- Word consumers pop on the 16-bit side; this block drives port B reads and qualifies the returned data.
- Owns pointers, occupancy count, flags and error reporting. The RAM instance is external, clocked by the same CLK.

Parameters:
AFULL_LEVEL, 480, byte count at or above which AFULL asserts (0..512)
AEMPTY_LEVEL, 4, byte count at or below which AEMPTY asserts (0..512)

Ports:
CLK  in  1  single clock, rising edge; also clocks both RAM ports
RST  in  1  asynchronous, active-high reset
DIN  in  8  write byte
WR_EN  in  1  write request
FULL  out  1  512 bytes held
AFULL  out  1  BYTE_COUNT >= AFULL_LEVEL
RD_EN  in  1  read-word request
DOUT  out  16  read word; equals RAM_DOB
DOUT_VALID  out  1  DOUT holds the word for the read accepted on the previous edge
EMPTY  out  1  BYTE_COUNT < 2
AEMPTY  out  1  BYTE_COUNT <= AEMPTY_LEVEL
BYTE_COUNT  out  10  occupancy in bytes, 0..512
OVERFLOW  out  1  sticky: write attempted while FULL
UNDERFLOW  out  1  sticky: read attempted while EMPTY
RAM_ADDRA  out  9  port A byte address
RAM_DIA  out  8  port A data
RAM_ENA  out  1  port A enable
RAM_WEA  out  1  port A write enable
RAM_RSTA  out  1  tied 0
RAM_ADDRB  out  8  port B word address
RAM_DIB  out  16  tied 0
RAM_ENB  out  1  port B enable
RAM_WEB  out  1  tied 0
RAM_RSTB  out  1  tied 0
RAM_DOB  in  16  port B read data

Behaviour:
- State: wr_ptr[9:0] (byte), rd_ptr[8:0] (word), count[9:0], DOUT_VALID, OVERFLOW, UNDERFLOW.
- Reset values (async on RST high): pointers 0, count 0, EMPTY 1, AEMPTY 1, FULL 0, AFULL 0, DOUT_VALID 0, OVERFLOW 0, UNDERFLOW 0. RAM contents are not cleared.
- Write accept: wr_acc = WR_EN & ~FULL.
  - RAM_ENA = RAM_WEA = wr_acc.
  - RAM_ADDRA = wr_ptr[8:0]; RAM_DIA = DIN.
  - wr_ptr increments modulo 1024 on accept.
- Read accept: rd_acc = RD_EN & ~EMPTY.
  - RAM_ENB = rd_acc; RAM_ADDRB = rd_ptr[7:0].
  - rd_ptr increments modulo 512 on accept.
- Byte order: even byte address maps to DOUT[7:0], odd to DOUT[15:8]. For example, bytes 0x11 then 0x22 read back as 16'h2211.
- Read latency: 1 cycle. DOUT_VALID is registered as rd_acc. DOUT is a combinational pass of RAM_DOB.
- Count update each edge: count + (wr_acc ? 1 : 0) - (rd_acc ? 2 : 0).
- Flags are combinational decodes of registered count:
  - FULL = (count == 512)
  - EMPTY = (count < 2)
  - AFULL = (count >= AFULL_LEVEL)
  - AEMPTY = (count <= AEMPTY_LEVEL)
- Simultaneous write and read: both accepted when their flags allow; net count change is -1.
- Read-during-write collision is impossible: a read only addresses bytes already committed in earlier cycles.
- An odd trailing byte stays in the FIFO (count 1, EMPTY 1) until its partner byte arrives.
- Errors:
  - WR_EN while FULL: write dropped, no RAM access, OVERFLOW set.
  - RD_EN while EMPTY: RAM_ENB 0, DOUT_VALID 0 next cycle, UNDERFLOW set.
  - Sticky flags clear only on RST.
- Wrap-around: byte address 511 wraps to 0 and word address 255 wraps to 0 with data order preserved.
- RST asserted mid-read: DOUT_VALID drops immediately (asynchronous).

Optional Feature:
- Macro: RAMB4_FIFO_FLUSH_EN.
- Defined: adds input FLUSH (1 bit). FLUSH high at an edge zeroes pointers and count, and clears DOUT_VALID.
  - It overrides any WR_EN/RD_EN in that cycle: no RAM enables are asserted that cycle.
  - It does not clear OVERFLOW or UNDERFLOW.
- Undefined: no FLUSH port; only RST empties the FIFO.

Test Plan:
- Write 0x11, 0x22, then RD_EN one cycle -> RAM_ADDRB=0, DOUT_VALID high the next cycle with DOUT=16'h2211; count goes 0, 1, 2, 0.
- Write 512 bytes (values i mod 256) -> FULL=1 and AFULL=1 at count 512. A 513th write gives RAM_WEA=0, OVERFLOW=1, count stays 512.
- With count=1, pulse RD_EN -> RAM_ENB=0, DOUT_VALID=0, UNDERFLOW=1; count stays 1.
- At count=2, assert WR_EN (0x33) and RD_EN together -> both accepted; count=1; next cycle DOUT valid.
- Stream 1200 bytes incrementing with continuous reads whenever not EMPTY -> word sequence 16'h0100, 16'h0302, ... is continuous across the 511->0 wrap; no OVERFLOW or UNDERFLOW.
- RST asserted between clock edges with count=300 -> all outputs reach reset values immediately. With RAMB4_FIFO_FLUSH_EN defined, FLUSH at count=40 with RD_EN high -> count=0, RAM_ENB=0.

Source files
------------

// File: rtl/ramb4_s8_s16_fifo_ctl_if.sv
// Bus bundle between the FIFO controller, its byte producer / word consumer and the
// external dual-port 8/16 block RAM.
//   slave  : the controller (takes requests and RAM read data, drives flags and RAM ports)
//   master : the surrounding logic (producer, consumer and RAM instance)
interface ramb4_s8_s16_fifo_ctl_if;
  // Producer side
  logic [7:0]  DIN;
  logic        WR_EN;
  logic        FULL;
  logic        AFULL;
  // Consumer side
  logic        RD_EN;
  logic [15:0] DOUT;
  logic        DOUT_VALID;
  logic        EMPTY;
  logic        AEMPTY;
  // Status
  logic [9:0]  BYTE_COUNT;
  logic        OVERFLOW;
  logic        UNDERFLOW;
  // RAM port A (512 x 8)
  logic [8:0]  RAM_ADDRA;
  logic [7:0]  RAM_DIA;
  logic        RAM_ENA;
  logic        RAM_WEA;
  logic        RAM_RSTA;
  // RAM port B (256 x 16)
  logic [7:0]  RAM_ADDRB;
  logic [15:0] RAM_DIB;
  logic        RAM_ENB;
  logic        RAM_WEB;
  logic        RAM_RSTB;
  logic [15:0] RAM_DOB;

  modport slave (
    input  DIN, WR_EN, RD_EN, RAM_DOB,
    output FULL, AFULL, DOUT, DOUT_VALID, EMPTY, AEMPTY, BYTE_COUNT, OVERFLOW, UNDERFLOW,
    output RAM_ADDRA, RAM_DIA, RAM_ENA, RAM_WEA, RAM_RSTA,
    output RAM_ADDRB, RAM_DIB, RAM_ENB, RAM_WEB, RAM_RSTB
  );

  modport master (
    output DIN, WR_EN, RD_EN, RAM_DOB,
    input  FULL, AFULL, DOUT, DOUT_VALID, EMPTY, AEMPTY, BYTE_COUNT, OVERFLOW, UNDERFLOW,
    input  RAM_ADDRA, RAM_DIA, RAM_ENA, RAM_WEA, RAM_RSTA,
    input  RAM_ADDRB, RAM_DIB, RAM_ENB, RAM_WEB, RAM_RSTB
  );
endinterface

// File: rtl/ramb4_s8_s16_fifo_ctl.sv
// Width-converting FIFO controller in front of a dual-port 8/16 block RAM.
// Bytes are written on port A (512 x 8), words are read on port B (256 x 16);
// even byte addresses land in DOUT[7:0], odd ones in DOUT[15:8].
//
// Ports:
//   CLK   - single rising-edge clock, shared with both RAM ports
//   RST   - asynchronous active-high reset
//   FLUSH - synchronous FIFO empty (only when RAMB4_FIFO_FLUSH_EN is defined)
//   bus   - slave modport: producer/consumer handshake, flags, status, RAM port A/B
//
// Optional feature macro: RAMB4_FIFO_FLUSH_EN adds the FLUSH input. FLUSH overrides any
// write/read that cycle and leaves OVERFLOW/UNDERFLOW untouched.
module ramb4_s8_s16_fifo_ctl #(
  parameter int unsigned AFULL_LEVEL  = 480,
  parameter int unsigned AEMPTY_LEVEL = 4
) (
  input  logic CLK,
  input  logic RST,
`ifdef RAMB4_FIFO_FLUSH_EN
  input  logic FLUSH,
`endif
  ramb4_s8_s16_fifo_ctl_if.slave bus
);

  localparam logic [9:0] AfullLvl  = 10'(AFULL_LEVEL);
  localparam logic [9:0] AemptyLvl = 10'(AEMPTY_LEVEL);

  logic [9:0] wr_ptr_q, wr_ptr_d;
  logic [8:0] rd_ptr_q, rd_ptr_d;
  logic [9:0] count_q, count_d;
  logic       dout_valid_q, dout_valid_d;
  logic       overflow_q, overflow_d;
  logic       underflow_q, underflow_d;

  logic full, empty, wr_acc, rd_acc, flush;

`ifdef RAMB4_FIFO_FLUSH_EN
  assign flush = FLUSH;
`else
  assign flush = 1'b0;
`endif

  // Pointer MSBs are lap bits; the RAM only sees the low address bits.
  logic unused_ptr_msbs;
  assign unused_ptr_msbs = wr_ptr_q[9] ^ rd_ptr_q[8];

  assign full  = (count_q == 10'd512);
  assign empty = (count_q < 10'd2);

  always_comb begin
    wr_acc = bus.WR_EN & ~full & ~flush;
    rd_acc = bus.RD_EN & ~empty & ~flush;

    wr_ptr_d     = wr_ptr_q + {9'd0, wr_acc};
    rd_ptr_d     = rd_ptr_q + {8'd0, rd_acc};
    count_d      = count_q + {9'd0, wr_acc} - (rd_acc ? 10'd2 : 10'd0);
    dout_valid_d = rd_acc;
    overflow_d   = overflow_q | (bus.WR_EN & full);
    underflow_d  = underflow_q | (bus.RD_EN & empty);

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      dout_valid_q <= 1'b0;
      overflow_q   <= 1'b0;
      underflow_q  <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      dout_valid_q <= dout_valid_d;
      overflow_q   <= overflow_d;
      underflow_q  <= underflow_d;
    end
  end

  // Flags and status
  assign bus.FULL       = full;
  assign bus.EMPTY      = empty;
  assign bus.AFULL      = (count_q >= AfullLvl);
  assign bus.AEMPTY     = (count_q <= AemptyLvl);
  assign bus.BYTE_COUNT = count_q;
  assign bus.OVERFLOW   = overflow_q;
  assign bus.UNDERFLOW  = underflow_q;

  // Read data comes straight from the RAM output register (1-cycle latency)
  assign bus.DOUT       = bus.RAM_DOB;
  assign bus.DOUT_VALID = dout_valid_q;

  // RAM port A: byte writes only
  assign bus.RAM_ADDRA = wr_ptr_q[8:0];
  assign bus.RAM_DIA   = bus.DIN;
  assign bus.RAM_ENA   = wr_acc;
  assign bus.RAM_WEA   = wr_acc;
  assign bus.RAM_RSTA  = 1'b0;

  // RAM port B: word reads only
  assign bus.RAM_ADDRB = rd_ptr_q[7:0];
  assign bus.RAM_DIB   = 16'h0000;
  assign bus.RAM_ENB   = rd_acc;
  assign bus.RAM_WEB   = 1'b0;
  assign bus.RAM_RSTB  = 1'b0;

endmodule

// File: tb/tb_ramb4_s8_s16_fifo_ctl.sv
// Directed self-checking bench for ramb4_s8_s16_fifo_ctl with a behavioural 8/16 RAM.
module tb_ramb4_s8_s16_fifo_ctl;
  logic CLK = 1'b0;
  logic RST = 1'b1;
`ifdef RAMB4_FIFO_FLUSH_EN
  logic FLUSH = 1'b0;
`endif

  int tests = 0;
  int fails = 0;

  ramb4_s8_s16_fifo_ctl_if bus ();

  ramb4_s8_s16_fifo_ctl #(
    .AFULL_LEVEL (480),
    .AEMPTY_LEVEL(4)
  ) dut (
    .CLK  (CLK),
    .RST  (RST),
`ifdef RAMB4_FIFO_FLUSH_EN
    .FLUSH(FLUSH),
`endif
    .bus  (bus)
  );

  always #5 CLK = ~CLK;

  // Behavioural dual-port RAM: 512 x 8 on A, 256 x 16 on B, registered read.
  logic [7:0] mem [512];
  always @(posedge CLK) begin
    if (bus.RAM_ENA && bus.RAM_WEA) mem[bus.RAM_ADDRA] <= bus.RAM_DIA;
    if (bus.RAM_ENB) bus.RAM_DOB <= {mem[{bus.RAM_ADDRB, 1'b1}], mem[{bus.RAM_ADDRB, 1'b0}]};
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    bus.WR_EN = 1'b0;
    bus.RD_EN = 1'b0;
  endtask

  task automatic push(input logic [7:0] b);
    bus.WR_EN = 1'b1;
    bus.DIN   = b;
    tick();
    bus.WR_EN = 1'b0;
  endtask

  int wr_n;
  int rd_words;
  logic [15:0] exp_w;

  initial begin
    bus.DIN   = 8'h00;
    idle();
    #2;
    // Reset state
    check("rst_empty", bus.EMPTY, 1);
    check("rst_aempty", bus.AEMPTY, 1);
    check("rst_full", bus.FULL, 0);
    check("rst_afull", bus.AFULL, 0);
    check("rst_count", bus.BYTE_COUNT, 0);
    check("rst_dvalid", bus.DOUT_VALID, 0);
    check("rst_ovf", bus.OVERFLOW, 0);
    check("rst_unf", bus.UNDERFLOW, 0);
    tick();
    RST = 1'b0;
    tick();

    // Two bytes then one word read
    bus.WR_EN = 1'b1;
    bus.DIN   = 8'h11;
    #1;
    check("wr0_wea", bus.RAM_WEA, 1);
    check("wr0_addra", bus.RAM_ADDRA, 0);
    check("wr0_dia", bus.RAM_DIA, 8'h11);
    tick();
    check("cnt_after_1", bus.BYTE_COUNT, 1);
    bus.DIN = 8'h22;
    tick();
    check("cnt_after_2", bus.BYTE_COUNT, 2);
    bus.WR_EN = 1'b0;
    bus.RD_EN = 1'b1;
    #1;
    check("rd0_enb", bus.RAM_ENB, 1);
    check("rd0_addrb", bus.RAM_ADDRB, 0);
    tick();
    bus.RD_EN = 1'b0;
    check("rd0_dvalid", bus.DOUT_VALID, 1);
    check("rd0_dout", bus.DOUT, 16'h2211);
    check("rd0_count", bus.BYTE_COUNT, 0);

    // Underflow with a single odd byte held
    push(8'hAA);
    check("odd_count", bus.BYTE_COUNT, 1);
    check("odd_empty", bus.EMPTY, 1);
    bus.RD_EN = 1'b1;
    #1;
    check("unf_enb", bus.RAM_ENB, 0);
    tick();
    bus.RD_EN = 1'b0;
    check("unf_dvalid", bus.DOUT_VALID, 0);
    check("unf_flag", bus.UNDERFLOW, 1);
    check("unf_count", bus.BYTE_COUNT, 1);

    // Simultaneous write and read at count 2
    push(8'h33);
    check("sim_pre_count", bus.BYTE_COUNT, 2);
    bus.WR_EN = 1'b1;
    bus.DIN   = 8'h44;
    bus.RD_EN = 1'b1;
    #1;
    check("sim_wea", bus.RAM_WEA, 1);
    check("sim_enb", bus.RAM_ENB, 1);
    check("sim_addra", bus.RAM_ADDRA, 4);
    check("sim_addrb", bus.RAM_ADDRB, 1);
    tick();
    idle();
    check("sim_count", bus.BYTE_COUNT, 1);
    check("sim_dvalid", bus.DOUT_VALID, 1);
    check("sim_dout", bus.DOUT, 16'h33AA);
    check("unf_sticky", bus.UNDERFLOW, 1);

    // Async reset between edges at count 300, with a read in flight
    RST = 1'b1;
    tick();
    RST = 1'b0;
    tick();
    for (int i = 0; i < 302; i++) push(8'(i));
    bus.RD_EN = 1'b1;
    tick();
    bus.RD_EN = 1'b0;
    check("pre_rst_count", bus.BYTE_COUNT, 300);
    check("pre_rst_dvalid", bus.DOUT_VALID, 1);
    #3;
    RST = 1'b1;
    #1;
    check("arst_count", bus.BYTE_COUNT, 0);
    check("arst_dvalid", bus.DOUT_VALID, 0);
    check("arst_empty", bus.EMPTY, 1);
    check("arst_aempty", bus.AEMPTY, 1);
    check("arst_unf", bus.UNDERFLOW, 0);
    tick();
    RST = 1'b0;
    tick();

    // Fill to 512, watch thresholds, then overflow
    for (int i = 0; i < 512; i++) begin
      push(8'(i));
      if (i == 3)   check("aempty_at4", bus.AEMPTY, 1);
      if (i == 4)   check("aempty_at5", bus.AEMPTY, 0);
      if (i == 478) check("afull_at479", bus.AFULL, 0);
      if (i == 479) check("afull_at480", bus.AFULL, 1);
      if (i == 510) check("full_at511", bus.FULL, 0);
    end
    check("full_count", bus.BYTE_COUNT, 512);
    check("full_flag", bus.FULL, 1);
    check("full_afull", bus.AFULL, 1);
    check("full_ovf0", bus.OVERFLOW, 0);
    bus.WR_EN = 1'b1;
    bus.DIN   = 8'hEE;
    #1;
    check("ovf_wea", bus.RAM_WEA, 0);
    check("ovf_ena", bus.RAM_ENA, 0);
    tick();
    bus.WR_EN = 1'b0;
    check("ovf_flag", bus.OVERFLOW, 1);
    check("ovf_count", bus.BYTE_COUNT, 512);
    bus.RD_EN = 1'b1;
    tick();
    check("full_rd0", bus.DOUT, 16'h0100);
    tick();
    bus.RD_EN = 1'b0;
    check("full_rd1", bus.DOUT, 16'h0302);
    check("full_rd_count", bus.BYTE_COUNT, 508);

    // Streaming across the address wrap
    RST = 1'b1;
    tick();
    RST = 1'b0;
    tick();
    wr_n = 0;
    rd_words = 0;
    for (int cyc = 0; cyc < 3000 && rd_words < 600; cyc++) begin
      bus.WR_EN = (wr_n < 1200);
      bus.DIN   = 8'(wr_n);
      bus.RD_EN = ~bus.EMPTY;
      tick();
      if (bus.WR_EN) wr_n++;
      if (bus.DOUT_VALID) begin
        exp_w = {8'(2 * rd_words + 1), 8'(2 * rd_words)};
        check("stream_word", bus.DOUT, exp_w);
        rd_words++;
      end
    end
    idle();
    check("stream_words", rd_words, 600);
    check("stream_ovf", bus.OVERFLOW, 0);
    check("stream_unf", bus.UNDERFLOW, 0);
    check("stream_count", bus.BYTE_COUNT, 0);

`ifdef RAMB4_FIFO_FLUSH_EN
    for (int i = 0; i < 40; i++) push(8'(i));
    check("fl_pre_count", bus.BYTE_COUNT, 40);
    FLUSH     = 1'b1;
    bus.RD_EN = 1'b1;
    #1;
    check("fl_enb", bus.RAM_ENB, 0);
    tick();
    FLUSH = 1'b0;
    idle();
    check("fl_count", bus.BYTE_COUNT, 0);
    check("fl_dvalid", bus.DOUT_VALID, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not reach the summary");
    $fatal(1, "timeout");
  end

endmodule
